fork_join_ctrl: RTL
===================

Name: fork_join_ctrl

Overview:
Hardware fork/join sequencer. It launches up to NUM_JOBS parallel worker units with a single start command, tracks their completion, and emits one continuation pulse (resume) according to the selected join mode: JOIN_ALL, JOIN_ANY or JOIN_NONE. It sits between a command issuer and a bank of independent workers, and includes a watchdog timeout and fork-to-resume latency measurement.

Parameters:
NUM_JOBS, 2, number of worker slots (1..16)
CNT_W, 16, width of the cycle counter and the resume_cycles output
TIMEOUT, 0, watchdog limit in cycles after FORK; 0 disables the watchdog

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  fork request; accepted only when start_ready=1
start_ready  out  1  high in IDLE
job_mask  in  NUM_JOBS  jobs to launch; sampled with an accepted start
join_mode  in  2  0=JOIN_ALL, 1=JOIN_ANY, 2=JOIN_NONE, 3=reserved (treated as JOIN_ALL); sampled with start
job_start  out  NUM_JOBS  one-cycle launch pulse per masked job
job_done  in  NUM_JOBS  one-cycle completion pulse from each worker
pending  out  NUM_JOBS  jobs launched but not yet done
busy  out  1  high whenever state != IDLE
resume  out  1  one-cycle continuation pulse, exactly once per accepted fork
resume_cycles  out  CNT_W  counter value latched at resume; held until the next resume
timeout  out  1  one-cycle watchdog pulse
timeout_mask  out  NUM_JOBS  jobs still pending at timeout; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except start_ready=1. A reset mid-fork abandons the fork with no resume and no timeout.
- States: IDLE, FORK, WAIT, RESUME. The internal flag resumed_q records whether resume has already fired for the current fork.
- IDLE: start=1 captures mask and mode, clears cnt, resumed_q and timeout_mask, then moves to FORK. If job_mask=0, the block moves to RESUME instead, and resume_cycles=0.
- FORK (exactly 1 cycle): job_start=mask_q and pending<=mask_q. cnt=0 in this cycle.
  - JOIN_NONE: resume=1 in this cycle, resume_cycles=0, resumed_q=1.
  - Then the block moves to WAIT.
- job_done is ignored in FORK. job_done bits for non-pending jobs are ignored everywhere.
- cnt increments every cycle in WAIT and RESUME and saturates at all-ones.
- WAIT: pending &= ~job_done.
  - JOIN_ANY: the first cycle with any done for a pending job, with resumed_q=0, moves to RESUME.
  - JOIN_ALL: the cycle in which pending becomes 0 moves to RESUME.
  - If resumed_q=1 and pending becomes 0, the block moves directly to IDLE (drain complete).
- RESUME (1 cycle): resume=1 and resume_cycles<=cnt.
  - Next state is IDLE if pending=0; otherwise WAIT with resumed_q=1 (JOIN_ANY drain).
- Latency: a worker asserts job_done N cycles after FORK. The pending bit clears at the end of that cycle; resume follows one cycle later with resume_cycles=N+1.
- Watchdog (TIMEOUT>0): in WAIT, when cnt==TIMEOUT and pending&~job_done != 0:
  - timeout=1 and timeout_mask<=pending&~job_done; pending is cleared.
  - Next state is RESUME if resumed_q=0, otherwise IDLE.
  - A done and a timeout in the same cycle: done wins for its bits.
- start is ignored while busy. No new fork is accepted until every launched job has completed or timed out.

Decomposition:
- Package fork_join_pkg holds:
  - join_mode_e (JOIN_ALL, JOIN_ANY, JOIN_NONE)
  - fj_state_e (IDLE, FORK, WAIT, RESUME)
  - constants JOIN_MODE_W=2 and MAX_JOBS=16
- One sub-module, fj_sat_counter (saturating CNT_W-bit counter with clear and enable), used for cnt.

Test Plan:
- JOIN_ALL, mask=2'b11; worker0 done at FORK+20, worker1 done at FORK+30 -> resume at FORK+31, resume_cycles=31, busy low at FORK+32, pending 11->10->00.
- JOIN_ANY, same stimulus -> resume at FORK+21 with resume_cycles=21; pending=2'b10 until FORK+30; busy low at FORK+31; exactly one resume.
- JOIN_NONE, same stimulus -> resume coincident with job_start at FORK+0, resume_cycles=0; busy high until FORK+31; start pulsed at FORK+10 is ignored (start_ready=0).
- TIMEOUT=25, JOIN_ALL, worker1 never completes -> timeout at FORK+25 with timeout_mask=2'b10, resume at FORK+26, resume_cycles=26, then IDLE.
- Edge cases:
  - job_mask=0 -> resume one cycle after start with resume_cycles=0 and no job_start.
  - Spurious job_done on an unlaunched job -> no effect.
  - Done at FORK+0 -> ignored.
- rst_n asserted at FORK+12 during JOIN_ALL -> all outputs 0 immediately, start_ready=1, no resume; a new fork after reset behaves normally.

Source files
------------

// File: rtl/fork_join_pkg.sv
// Shared types and constants for the fork/join sequencer.
package fork_join_pkg;

  localparam int unsigned JOIN_MODE_W = 2;
  localparam int unsigned MAX_JOBS    = 16;

  typedef enum logic [JOIN_MODE_W-1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FORK   = 2'd1,
    WAIT   = 2'd2,
    RESUME = 2'd3
  } fj_state_e;

  // The reserved encoding behaves as JOIN_ALL.
  function automatic join_mode_e decode_mode(input logic [JOIN_MODE_W-1:0] raw);
    unique case (raw)
      2'd1:    decode_mode = JOIN_ANY;
      2'd2:    decode_mode = JOIN_NONE;
      default: decode_mode = JOIN_ALL;
    endcase
  endfunction

endpackage

// File: rtl/fj_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over enable).
module fj_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count up, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches masked jobs, tracks completion, and issues one resume pulse
// per accepted fork according to the join mode, with an optional watchdog.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int unsigned NUM_JOBS = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   start_ready,
  input  logic [NUM_JOBS-1:0]    job_mask,
  input  logic [JOIN_MODE_W-1:0] join_mode,
  output logic [NUM_JOBS-1:0]    job_start,
  input  logic [NUM_JOBS-1:0]    job_done,
  output logic [NUM_JOBS-1:0]    pending,
  output logic                   busy,
  output logic                   resume,
  output logic [CNT_W-1:0]       resume_cycles,
  output logic                   timeout,
  output logic [NUM_JOBS-1:0]    timeout_mask
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  fj_state_e            state_q, state_d;
  join_mode_e           mode_q, mode_d;
  logic [NUM_JOBS-1:0]  mask_q, mask_d;
  logic [NUM_JOBS-1:0]  pending_q, pending_d;
  logic [NUM_JOBS-1:0]  tmask_q, tmask_d;
  logic [CNT_W-1:0]     rcyc_q, rcyc_d;
  logic                 resumed_q, resumed_d;
  logic                 cnt_clr, cnt_en;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_JOBS-1:0]  done_eff, pend_left;
  logic                 wd_hit;

  fj_sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt)
  );

  assign done_eff  = job_done & pending_q;
  assign pend_left = pending_q & ~job_done;
  // Done bits are removed before the watchdog looks, so a same-cycle done wins.
  assign wd_hit    = (TIMEOUT != 0) && (state_q == WAIT) && (cnt == TimeoutVal) && (|pend_left);
  assign cnt_en    = (state_q != IDLE);

  // Next-state and pulse outputs.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    pending_d   = pending_q;
    tmask_d     = tmask_q;
    rcyc_d      = rcyc_q;
    resumed_d   = resumed_q;
    cnt_clr     = 1'b0;
    start_ready = 1'b0;
    job_start   = '0;
    resume      = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start) begin
          mask_d    = job_mask;
          mode_d    = decode_mode(join_mode);
          cnt_clr   = 1'b1;
          resumed_d = 1'b0;
          tmask_d   = '0;
          state_d   = (|job_mask) ? FORK : RESUME;
        end
      end
      FORK: begin
        job_start = mask_q;
        pending_d = mask_q;
        if (mode_q == JOIN_NONE) begin
          resume    = 1'b1;
          rcyc_d    = '0;
          resumed_d = 1'b1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        pending_d = pend_left;
        if (wd_hit) begin
          timeout   = 1'b1;
          tmask_d   = pend_left;
          pending_d = '0;
          state_d   = resumed_q ? IDLE : RESUME;
        end else if (pend_left == '0) begin
          state_d = resumed_q ? IDLE : RESUME;
        end else if (!resumed_q && (mode_q == JOIN_ANY) && (|done_eff)) begin
          state_d = RESUME;
        end
      end
      RESUME: begin
        resume    = 1'b1;
        rcyc_d    = cnt;
        // A done landing in this cycle still retires its job so the drain cannot stall.
        pending_d = pend_left;
        if (|pend_left) begin
          resumed_d = 1'b1;
          state_d   = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= JOIN_ALL;
      mask_q    <= '0;
      pending_q <= '0;
      tmask_q   <= '0;
      rcyc_q    <= '0;
      resumed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      tmask_q   <= tmask_d;
      rcyc_q    <= rcyc_d;
      resumed_q <= resumed_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign pending       = pending_q;
  assign resume_cycles = rcyc_q;
  assign timeout_mask  = tmask_q;

endmodule
